// File: rtl/sifh_peak_reader.sv
// Histogram RAM readout: sweeps every bin of every pixel, reports each pixel's
// peak bin and count, and clears every bin read so the RAM is empty again.
module sifh_peak_reader #(
  parameter int NB                = 6,
  parameter int PEAK_MAX          = 8,
  parameter int BIN_NUM_PER_HIS   = 16,
  parameter int PIXEL_NUM_PER_RAM = 4,
  parameter int BW                = 4,
  parameter int PW                = 2
) (
  input  logic                clk,
  input  logic                res,
  input  logic                start,
  input  logic [PEAK_MAX-1:0] counts,
  output logic [NB-1:0]       raddr,
  output logic                rEnable,
  output logic                readFlag,
  output logic [NB-1:0]       waddr,
  output logic                wEnable,
  output logic                writeFlag,
  output logic [PEAK_MAX-1:0] newCounts,
  output logic                busy,
  output logic                peak_valid,
  output logic [PW-1:0]       peak_pixel,
  output logic [BW-1:0]       peak_bin,
  output logic [PEAK_MAX-1:0] peak_count,
  output logic                done
);

  localparam logic [NB-1:0] LAST_ADDR = NB'(BIN_NUM_PER_HIS * PIXEL_NUM_PER_RAM - 1);
  localparam logic [BW-1:0] LAST_BIN  = BW'(BIN_NUM_PER_HIS - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, FLUSH, DONE} state_t;

  state_t              state_q, state_d;
  logic [NB-1:0]       a_q, a_d;
  logic [BW-1:0]       b_q, b_d;
  logic [PW-1:0]       p_q, p_d;
  logic                vld_p1_q, vld_p1_d;
  logic [NB-1:0]       a_p1_q, a_p1_d;
  logic [BW-1:0]       b_p1_q, b_p1_d;
  logic [PW-1:0]       p_p1_q, p_p1_d;
  logic [PEAK_MAX-1:0] max_q, max_d;
  logic [BW-1:0]       maxbin_q, maxbin_d;
  logic                peak_valid_q, peak_valid_d;
  logic [PW-1:0]       peak_pixel_q, peak_pixel_d;
  logic [BW-1:0]       peak_bin_q, peak_bin_d;
  logic [PEAK_MAX-1:0] peak_count_q, peak_count_d;
  logic [PEAK_MAX-1:0] cur_max;
  logic [BW-1:0]       cur_bin;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      p_q          <= '0;
      vld_p1_q     <= 1'b0;
      a_p1_q       <= '0;
      b_p1_q       <= '0;
      p_p1_q       <= '0;
      max_q        <= '0;
      maxbin_q     <= '0;
      peak_valid_q <= 1'b0;
      peak_pixel_q <= '0;
      peak_bin_q   <= '0;
      peak_count_q <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      p_q          <= p_d;
      vld_p1_q     <= vld_p1_d;
      a_p1_q       <= a_p1_d;
      b_p1_q       <= b_p1_d;
      p_p1_q       <= p_p1_d;
      max_q        <= max_d;
      maxbin_q     <= maxbin_d;
      peak_valid_q <= peak_valid_d;
      peak_pixel_q <= peak_pixel_d;
      peak_bin_q   <= peak_bin_d;
      peak_count_q <= peak_count_d;
    end
  end

  // Compare stage: bin 0 seeds the running max; strict > keeps the lowest bin on ties.
  always_comb begin
    cur_max = max_q;
    cur_bin = maxbin_q;
    if (b_p1_q == '0) begin
      cur_max = counts;
      cur_bin = '0;
    end else if (counts > max_q) begin
      cur_max = counts;
      cur_bin = b_p1_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    p_d          = p_q;
    vld_p1_d     = 1'b0;
    a_p1_d       = a_p1_q;
    b_p1_d       = b_p1_q;
    p_p1_d       = p_p1_q;
    max_d        = max_q;
    maxbin_d     = maxbin_q;
    peak_valid_d = 1'b0;
    peak_pixel_d = peak_pixel_q;
    peak_bin_d   = peak_bin_q;
    peak_count_d = peak_count_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SWEEP;
          a_d     = '0;
          b_d     = '0;
          p_d     = '0;
        end
      end
      SWEEP: begin
        vld_p1_d = 1'b1;
        a_p1_d   = a_q;
        b_p1_d   = b_q;
        p_p1_d   = p_q;
        a_d      = a_q + NB'(1);
        if (b_q == LAST_BIN) begin
          b_d = '0;
          p_d = p_q + PW'(1);
        end else begin
          b_d = b_q + BW'(1);
        end
        if (a_q == LAST_ADDR) state_d = FLUSH;
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (vld_p1_q) begin
      max_d    = cur_max;
      maxbin_d = cur_bin;
      if (b_p1_q == LAST_BIN) begin
        peak_valid_d = 1'b1;
        peak_pixel_d = p_p1_q;
        peak_bin_d   = cur_bin;
        peak_count_d = cur_max;
      end
    end
  end

  // Reads issue from the live counter; the clear write trails by one cycle on the delayed address.
  assign rEnable    = (state_q == SWEEP);
  assign readFlag   = rEnable;
  assign raddr      = rEnable ? a_q : '0;
  assign wEnable    = vld_p1_q;
  assign writeFlag  = vld_p1_q;
  assign waddr      = vld_p1_q ? a_p1_q : '0;
  assign newCounts  = '0;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign peak_valid = peak_valid_q;
  assign peak_pixel = peak_pixel_q;
  assign peak_bin   = peak_bin_q;
  assign peak_count = peak_count_q;

endmodule

// File: tb/tb_sifh_peak_reader.sv
// Bench for sifh_peak_reader: RAM model with write bookkeeping, per-pixel peak
// reference computed from a snapshot of RAM contents taken before each sweep.
module tb_sifh_peak_reader;

  localparam int NB = 6, PM = 8, BIN = 16, PIX = 4, BW = 4, PW = 2;
  localparam int WORDS = BIN * PIX;

  logic          clk = 1'b0;
  logic          res = 1'b1;
  logic          start = 1'b0;
  logic [PM-1:0] counts;
  logic [NB-1:0] raddr, waddr;
  logic          rEnable, readFlag, wEnable, writeFlag;
  logic [PM-1:0] newCounts;
  logic          busy, peak_valid, done;
  logic [PW-1:0] peak_pixel;
  logic [BW-1:0] peak_bin;
  logic [PM-1:0] peak_count;

  sifh_peak_reader #(
    .NB(NB), .PEAK_MAX(PM), .BIN_NUM_PER_HIS(BIN), .PIXEL_NUM_PER_RAM(PIX), .BW(BW), .PW(PW)
  ) dut (
    .clk(clk), .res(res), .start(start), .counts(counts),
    .raddr(raddr), .rEnable(rEnable), .readFlag(readFlag),
    .waddr(waddr), .wEnable(wEnable), .writeFlag(writeFlag), .newCounts(newCounts),
    .busy(busy), .peak_valid(peak_valid), .peak_pixel(peak_pixel),
    .peak_bin(peak_bin), .peak_count(peak_count), .done(done)
  );

  always #5 clk = ~clk;

  logic [PM-1:0] mem [WORDS];
  logic [PM-1:0] img [WORDS];
  logic [PM-1:0] snap [WORDS];
  logic [PM-1:0] rdata = '0;
  logic          ren_prev = 1'b0;
  logic [NB-1:0] raddr_prev = '0;
  int            wcnt [WORDS];
  int            port_bad = 0;
  int            ecnt = 0;
  bit            load = 1'b0;
  bit            clr = 1'b0;
  int            npk = 0, ndone = 0;
  int            pk_pix [8], pk_bin [8], pk_cnt [8];
  int            exp_bin [PIX], exp_cnt [PIX];
  int            checks = 0, failures = 0;

  assign counts = rdata;

  // RAM model: registered read port, write port, per-address write counts
  always @(posedge clk) begin
    ecnt <= ecnt + 1;
    if (load) for (int i = 0; i < WORDS; i++) mem[i] <= img[i];
    else if (wEnable) mem[waddr] <= newCounts;
    if (rEnable) rdata <= mem[raddr];
    if (clr) begin
      for (int i = 0; i < WORDS; i++) wcnt[i] <= 0;
      port_bad <= 0;
    end else begin
      if (wEnable) begin
        wcnt[waddr] <= wcnt[waddr] + 1;
        if (!ren_prev || waddr != raddr_prev || newCounts != '0) port_bad <= port_bad + 1;
      end
      if (rEnable != readFlag || wEnable != writeFlag) port_bad <= port_bad + 1;
    end
    ren_prev   <= rEnable;
    raddr_prev <= raddr;
  end

  always @(negedge clk) begin
    if (clr) begin
      npk   <= 0;
      ndone <= 0;
    end else begin
      if (peak_valid) begin
        if (npk < 8) begin
          pk_pix[npk] <= int'(peak_pixel);
          pk_bin[npk] <= int'(peak_bin);
          pk_cnt[npk] <= int'(peak_count);
        end
        npk <= npk + 1;
      end
      if (done) ndone <= ndone + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic prep(input bit do_load);
    @(posedge clk); #1;
    load = do_load;
    clr  = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    clr  = 1'b0;
  endtask

  // Reference: peak value is the maximum of the pixel's bins; reported bin is the first holding it
  task automatic compute_exp();
    int mx;
    for (int i = 0; i < WORDS; i++) snap[i] = mem[i];
    for (int p = 0; p < PIX; p++) begin
      mx = 0;
      for (int b = 0; b < BIN; b++) if (int'(snap[p*BIN+b]) > mx) mx = int'(snap[p*BIN+b]);
      exp_cnt[p] = mx;
      exp_bin[p] = -1;
      for (int b = 0; b < BIN; b++) if (exp_bin[p] < 0 && int'(snap[p*BIN+b]) == mx) exp_bin[p] = b;
    end
  endtask

  task automatic check_results(input string tag);
    int bad_w, nz;
    chk({tag, "_npk"}, npk, PIX);
    chk({tag, "_ndone"}, ndone, 1);
    for (int p = 0; p < PIX; p++) begin
      chk($sformatf("%s_p%0d_pixel", tag, p), pk_pix[p], p);
      chk($sformatf("%s_p%0d_bin", tag, p), pk_bin[p], exp_bin[p]);
      chk($sformatf("%s_p%0d_count", tag, p), pk_cnt[p], exp_cnt[p]);
    end
    bad_w = 0;
    nz = 0;
    for (int i = 0; i < WORDS; i++) begin
      if (wcnt[i] != 1) bad_w++;
      if (mem[i] != '0) nz++;
    end
    chk({tag, "_write_once"}, bad_w, 0);
    chk({tag, "_ram_zero"}, nz, 0);
    chk({tag, "_port"}, port_bad, 0);
  endtask

  task automatic wait_done(input string tag, input int s_e);
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk); #1;
    end
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_start_to_done_edges"}, ecnt - s_e + 1, WORDS + 3);
    chk({tag, "_last_valid_with_done"}, peak_valid, 1);
  endtask

  task automatic run_sweep(input bit do_load, input string tag);
    int s_e;
    prep(do_load);
    compute_exp();
    start = 1'b1;
    s_e = ecnt;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_first_raddr"}, raddr, 0);
    chk({tag, "_first_ren"}, rEnable, 1);
    chk({tag, "_busy"}, busy, 1);
    wait_done(tag, s_e);
    @(posedge clk); #1;
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_done_one_cycle"}, done, 0);
    check_results(tag);
  endtask

  initial begin
    int s_e, npk_at_rst, bad, busy_hi;

    #1;
    chk("rst_raddr", raddr, 0);
    chk("rst_ren", rEnable, 0);
    chk("rst_wen", wEnable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_peak_valid", peak_valid, 0);
    chk("rst_peak_count", peak_count, 0);
    chk("rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 res = 1'b0;

    // Single peak: pixel 2 bin 9 = 200, rest of pixel 2 = 3, other pixels empty
    for (int i = 0; i < WORDS; i++) img[i] = (i / BIN == 2) ? 8'd3 : 8'd0;
    img[2*BIN+9] = 8'd200;
    run_sweep(1'b1, "single_peak");

    // Tie in pixel 0, last-bin peak in pixel 1, first-bin peak in pixel 3
    for (int b = 0; b < BIN; b++) begin
      img[0*BIN+b] = 8'd20;
      img[1*BIN+b] = 8'd100;
      img[2*BIN+b] = PM'($urandom_range(0, 199));
      img[3*BIN+b] = 8'd6;
    end
    img[0*BIN+4]  = 8'd50;
    img[0*BIN+11] = 8'd50;
    img[1*BIN+15] = 8'd255;
    img[3*BIN+0]  = 8'd7;
    run_sweep(1'b1, "tie_boundary");

    run_sweep(1'b0, "clear_check");

    for (int i = 0; i < WORDS; i++) img[i] = PM'($urandom_range(0, 255));
    run_sweep(1'b1, "rand_full");
    for (int i = 0; i < WORDS; i++) img[i] = PM'($urandom_range(0, 5));
    run_sweep(1'b1, "rand_ties");

    // Reset mid-sweep: reset lands right after the edge that closes cycle 30
    for (int i = 0; i < WORDS; i++) img[i] = PM'($urandom_range(1, 255));
    prep(1'b1);
    for (int i = 0; i < WORDS; i++) snap[i] = mem[i];
    start = 1'b1;
    s_e = ecnt;
    @(posedge clk); #1;
    start = 1'b0;
    while (ecnt - s_e < 30) @(posedge clk);
    #1 res = 1'b1;
    #1;
    chk("midrst_raddr", raddr, 0);
    chk("midrst_ren", rEnable, 0);
    chk("midrst_rflag", readFlag, 0);
    chk("midrst_waddr", waddr, 0);
    chk("midrst_wen", wEnable, 0);
    chk("midrst_wflag", writeFlag, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_peak_valid", peak_valid, 0);
    chk("midrst_peak_pixel", peak_pixel, 0);
    chk("midrst_peak_bin", peak_bin, 0);
    chk("midrst_peak_count", peak_count, 0);
    chk("midrst_done", done, 0);
    npk_at_rst = npk;
    repeat (3) @(posedge clk);
    #1 res = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    chk("midrst_no_done", ndone, 0);
    chk("midrst_no_new_valid", npk, npk_at_rst);
    bad = 0;
    for (int i = 0; i < 28; i++) if (mem[i] != '0) bad++;
    chk("midrst_cleared_low", bad, 0);
    bad = 0;
    for (int i = 29; i < WORDS; i++) if (mem[i] != snap[i]) bad++;
    chk("midrst_untouched_high", bad, 0);
    run_sweep(1'b0, "post_reset");

    // Extra start pulses while busy and in the done cycle are ignored
    for (int i = 0; i < WORDS; i++) img[i] = PM'($urandom_range(0, 255));
    prep(1'b1);
    compute_exp();
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    s_e = ecnt;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("multi_busy_mid", busy, 1);
    wait_done("multi", s_e);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("multi_busy_after_done", busy, 0);
    busy_hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy || rEnable) busy_hi++;
    end
    chk("multi_no_second_sweep", busy_hi, 0);
    check_results("multi");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
